// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module  : mem_access_unit_pkg
// Purpose : Shared size encodings, FSM state type and alignment helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Reserved size is folded in here so the top needs only one error term.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            SZ_RSV:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module  : mem_lane_align
// Purpose : Little-endian lane extract/extend for loads and lane merge for stores.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b  = word_i[7:0];
        lane_h  = word_i[15:0];
        load_o  = word_i;
        store_o = word_i;
        case (size_i)
            SZ_B: begin
                case (off_i)
                    2'd0: begin lane_b = word_i[7:0];   store_o[7:0]   = wdata_i[7:0]; end
                    2'd1: begin lane_b = word_i[15:8];  store_o[15:8]  = wdata_i[7:0]; end
                    2'd2: begin lane_b = word_i[23:16]; store_o[23:16] = wdata_i[7:0]; end
                    default: begin lane_b = word_i[31:24]; store_o[31:24] = wdata_i[7:0]; end
                endcase
                load_o = {{24{lane_b[7] & ~unsigned_i}}, lane_b};
            end
            SZ_H: begin
                if (off_i[1]) begin
                    lane_h         = word_i[31:16];
                    store_o[31:16] = wdata_i[15:0];
                end else begin
                    lane_h         = word_i[15:0];
                    store_o[15:0]  = wdata_i[15:0];
                end
                load_o = {{16{lane_h[15] & ~unsigned_i}}, lane_h};
            end
            SZ_W: begin
                store_o = wdata_i;
            end
            default: begin
                load_o  = word_i;
                store_o = word_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Purpose : Single-outstanding load/store controller for a word-addressed RAM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_input,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    input  logic [DATA_W-1:0] ram_data_output
);

    state_t              state_q, state_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          off_q, off_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                ram_we_q, ram_we_d;
    logic                ram_re_q, ram_re_d;

    logic                req_bad;
    logic [31:0]         load_word;
    logic [31:0]         merge_word;

    assign req_bad = size_misaligned(req_size, req_addr[1:0]) | (|req_addr[31:ADDR_W+2]);

    mem_lane_align u_align (
        .word_i     (ram_data_output),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_word),
        .store_o    (merge_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
        end
    end

    // Strobes default low each cycle; they are raised on the edge entering
    // the state that owns them, so each is exactly one cycle wide.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        addr_d      = addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = req_bad;
                    if (req_bad) begin
                        state_d = ST_RESP;
                    end else begin
                        addr_d = req_addr[ADDR_W+1:2];
                        if (!req_we) begin
                            state_d  = ST_RD;
                            ram_re_d = 1'b1;
                        end else if (req_size == SZ_W) begin
                            state_d     = ST_WR;
                            ram_we_d    = 1'b1;
                            ram_wdata_d = req_wdata;
                        end else begin
                            state_d  = ST_RMW_RD;
                            ram_re_d = 1'b1;
                        end
                    end
                end
            end
            ST_RD: begin
                rdata_d = load_word;
                state_d = ST_RESP;
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                ram_wdata_d = merge_word;
                ram_we_d    = 1'b1;
                state_d     = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign resp_valid       = (state_q == ST_RESP);
    assign resp_rdata       = rdata_q;
    assign resp_err         = err_q;
    assign ram_address      = addr_q;
    assign ram_data_input   = ram_wdata_q;
    assign ram_write_enable = ram_we_q;
    assign ram_read_enable  = ram_re_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Purpose : Directed scoreboard bench for mem_access_unit with a behavioural RAM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam int ADDR_W = 16;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_data_input;
    logic              ram_write_enable;
    logic              ram_read_enable;
    logic [31:0]       ram_data_output;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    logic        in_resp;
    int          n_vec;
    int          n_err;
    int          cyc;
    int          acc_cyc;
    int          wr_cnt;
    int          rd_cnt;
    logic [ADDR_W-1:0] last_wa;
    logic [31:0] mem [0:(1<<ADDR_W)-1];

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .ram_address      (ram_address),
        .ram_data_input   (ram_data_input),
        .ram_write_enable (ram_write_enable),
        .ram_read_enable  (ram_read_enable),
        .ram_data_output  (ram_data_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ram_data_output = mem[ram_address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (ram_write_enable) begin
            mem[ram_address] = ram_data_input;
            last_wa = ram_address;
            wr_cnt++;
        end
        if (ram_read_enable) rd_cnt++;
        if (ram_write_enable && ram_read_enable) begin
            n_vec++;
            n_err++;
            $display("FAIL strobe_overlap: got both enables high expected one at most");
        end
    end

    // Monitor samples just after the falling edge so bench-driven inputs are settled.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            in_resp = 1'b0;
        end else if (resp_valid) begin
            if (!in_resp) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_resp: got rdata %h err %b expected no response", resp_rdata, resp_err);
                end else begin
                    cur = sb_q.pop_front();
                    check("resp_rdata", resp_rdata, cur.rdata);
                    check("resp_err", {31'd0, resp_err}, {31'd0, cur.err});
                    check("latency", cyc - acc_cyc + 1, cur.lat);
                end
            end else begin
                check("hold_rdata", resp_rdata, cur.rdata);
                check("hold_err", {31'd0, resp_err}, {31'd0, cur.err});
            end
            in_resp = !resp_ready;
        end
    end

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic push, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat);
        int t;
        exp_t e;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = exp_lat;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || in_resp || resp_valid) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("drain_timeout", t, 0);
        @(negedge clk);
    endtask

    int w0, r0, t;
    initial begin
        n_vec = 0; n_err = 0; cyc = 0; acc_cyc = 0;
        wr_cnt = 0; rd_cnt = 0; last_wa = '0; in_resp = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_ram_en", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);
        check("rst_ram_addr", {16'd0, ram_address}, 32'd0);
        check("rst_ram_din", ram_data_input, 32'd0);

        // Word store then load
        w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 2);
        drain();
        check("sw_wr_count", wr_cnt - w0, 1);
        check("sw_wr_addr", {16'd0, last_wa}, 32'd4);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2);
        drain();

        // Byte store read-modify-write and byte loads
        mem[4] = 32'h1122_3344;
        w0 = wr_cnt; r0 = rd_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'h0000_00AA, 1'b1, 32'h0, 1'b0, 3);
        drain();
        check("sb_mem", mem[4], 32'h11AA_3344);
        check("sb_strobes", {wr_cnt - w0, rd_cnt - r0}, {32'd1, 32'd1});
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0, 1'b1, 32'hFFFF_FFAA, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0, 1'b1, 32'h0000_00AA, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 1'b1, 32'h0000_0011, 1'b0, 2);
        drain();

        // Half loads and sub-word stores on other lanes
        mem[4] = 32'h8001_7FFF;
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0, 2);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h0000_7FFF, 1'b0, 2);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234_BEEF, 1'b1, 32'h0, 1'b0, 3);
        drain();
        check("sh_mem", mem[4], 32'hBEEF_7FFF);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'hFFFF_FF55, 1'b1, 32'h0, 1'b0, 3);
        drain();
        check("sb0_mem", mem[4], 32'hBEEF_7F55);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0, 2);
        drain();

        // Error cases: no RAM strobes, err after one cycle
        w0 = wr_cnt; r0 = rd_cnt;
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h0004_0000, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b1, 2'b00, 1'b0, 32'h0004_0010, 32'h0000_0077, 1'b1, 32'h0, 1'b1, 1);
        drain();
        check("err_no_strobes", {wr_cnt - w0, rd_cnt - r0}, {32'd0, 32'd0});
        check("err_mem_intact", mem[4], 32'hBEEF_7F55);

        // Top legal word address
        issue(1'b1, 2'b10, 1'b0, 32'h0003_FFFC, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 2);
        drain();
        check("top_wr_addr", {16'd0, last_wa}, 32'h0000_FFFF);
        issue(1'b0, 2'b10, 1'b0, 32'h0003_FFFC, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 2);
        drain();

        // Backpressure then back-to-back request
        resp_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hBEEF_7F55, 1'b0, 2);
        t = 0;
        while (!resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp_resp_seen", {31'd0, resp_valid}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_next", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 2'b00, 1'b1, 32'h0003_FFFF, 32'h0, 1'b1, 32'h0000_00CA, 1'b0, 2);
        check("b2b_accept_cycle", acc_cyc - cyc, 0);
        drain();

        // Reset during RMW_RD: no write, no response
        mem[8] = 32'h1234_5678;
        w0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h0000_00FF, 1'b0, 32'h0, 1'b0, 0);
        check("rmw_rd_active", {31'd0, ram_read_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_en", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_write", wr_cnt - w0, 0);
        check("rst_mem_intact", mem[8], 32'h1234_5678);
        check("rst_req_ready2", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid2", {31'd0, resp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
